// File: rtl/gobang_pkg.sv
// Shared board geometry, cell encodings and index helpers for the gobang turn datapath.
package gobang_pkg;

  localparam int unsigned BOARD_SIZE = 15;
  localparam int unsigned CENTER     = 7;
  localparam int unsigned MAX_STONES = 225;
  localparam int unsigned NUM_CELLS  = BOARD_SIZE * BOARD_SIZE;

  typedef logic [1:0] cell_t;
  typedef logic [3:0] coord_t;
  typedef logic [7:0] cell_idx_t;
  typedef logic [7:0] count_t;

  localparam cell_t EMPTY = 2'b00;
  localparam cell_t BLACK = 2'b01;
  localparam cell_t WHITE = 2'b10;

  localparam coord_t    COORD_MAX  = coord_t'(BOARD_SIZE - 1);
  localparam coord_t    COORD_CTR  = coord_t'(CENTER);
  localparam cell_idx_t LAST_IDX   = cell_idx_t'(NUM_CELLS - 1);
  localparam count_t    FULL_COUNT = count_t'(MAX_STONES);

  // Row-major linear index of a board coordinate.
  function automatic cell_idx_t cell_idx(coord_t x, coord_t y);
    return cell_idx_t'(y) * cell_idx_t'(BOARD_SIZE) + cell_idx_t'(x);
  endfunction

  function automatic logic coord_ok(coord_t c);
    return c <= COORD_MAX;
  endfunction

endpackage

// File: rtl/turn_datapath_if.sv
// Handshake bundle between the game FSM / display and the turn datapath.
interface turn_datapath_if;
  import gobang_pkg::*;

  logic   change_able_read;
  logic   change_turn;
  logic   control_set;
  logic   put;
  logic   move_up;
  logic   move_down;
  logic   move_left;
  logic   move_right;
  coord_t rd_x;
  coord_t rd_y;
  cell_t  rd_cell;
  coord_t pointer_x;
  coord_t pointer_y;
  logic   player;
  logic   legal;
  count_t stone_count;
  logic   board_full;

  // Game FSM / display side.
  modport master (
    output change_able_read, change_turn, control_set, put,
    output move_up, move_down, move_left, move_right, rd_x, rd_y,
    input  rd_cell, pointer_x, pointer_y, player, legal, stone_count, board_full
  );

  // Datapath side.
  modport slave (
    input  change_able_read, change_turn, control_set, put,
    input  move_up, move_down, move_left, move_right, rd_x, rd_y,
    output rd_cell, pointer_x, pointer_y, player, legal, stone_count, board_full
  );

endinterface

// File: rtl/board_regs.sv
// 15x15 board register file: one synchronous write port, two combinational read ports.
module board_regs
  import gobang_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      we_i,
  input  cell_idx_t waddr_i,
  input  cell_t     wdata_i,
  input  cell_idx_t raddr_a_i,
  output cell_t     rdata_a_o,
  input  cell_idx_t raddr_b_i,
  output cell_t     rdata_b_o
);

  cell_t mem_q [NUM_CELLS];

  // Cell storage; whole board clears on reset, single cell written per commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_CELLS; i++) begin
        mem_q[i] <= EMPTY;
      end
    end else if (we_i && (waddr_i <= LAST_IDX)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range addresses read as empty rather than indexing past the array.
  always_comb begin
    rdata_a_o = EMPTY;
    rdata_b_o = EMPTY;
    if (raddr_a_i <= LAST_IDX) rdata_a_o = mem_q[raddr_a_i];
    if (raddr_b_i <= LAST_IDX) rdata_b_o = mem_q[raddr_b_i];
  end

endmodule

// File: rtl/turn_datapath.sv
// Turn datapath: pointer counters, legality latch, side-to-move flop, stone counter.
module turn_datapath
  import gobang_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  turn_datapath_if.slave dp_io
);

  coord_t ptr_x_q, ptr_x_d;
  coord_t ptr_y_q, ptr_y_d;
  logic   player_q, player_d;
  logic   legal_q, legal_d;
  count_t count_q, count_d;

  logic      board_full;
  logic      commit;
  logic      move_en;
  logic      rd_ok;
  cell_t     ptr_cell;
  cell_t     rd_raw;
  cell_t     wdata;
  cell_idx_t ptr_idx;
  cell_idx_t rd_idx;

  assign board_full = (count_q == FULL_COUNT);
  assign commit     = dp_io.change_turn & legal_q & ~board_full;
  // A put in the same cycle freezes the pointer so legality refers to the pre-move cell.
  assign move_en    = dp_io.change_able_read & ~dp_io.put;
  assign ptr_idx    = cell_idx(ptr_x_q, ptr_y_q);
  assign rd_ok      = coord_ok(dp_io.rd_x) & coord_ok(dp_io.rd_y);
  assign rd_idx     = rd_ok ? cell_idx(dp_io.rd_x, dp_io.rd_y) : '0;
  assign wdata      = player_q ? WHITE : BLACK;

  board_regs u_board (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .we_i      (commit),
    .waddr_i   (ptr_idx),
    .wdata_i   (wdata),
    .raddr_a_i (ptr_idx),
    .rdata_a_o (ptr_cell),
    .raddr_b_i (rd_idx),
    .rdata_b_o (rd_raw)
  );

  // Next-state for legality, turn commit and pointer movement.
  always_comb begin
    ptr_x_d  = ptr_x_q;
    ptr_y_d  = ptr_y_q;
    player_d = player_q;
    legal_d  = legal_q;
    count_d  = count_q;

    if (dp_io.change_turn) begin
      legal_d = 1'b0;
      if (commit) begin
        player_d = ~player_q;
        count_d  = count_q + 8'd1;
      end
    end else if (dp_io.change_able_read && dp_io.put) begin
      legal_d = (ptr_cell == EMPTY) & ~board_full;
    end

    if (dp_io.control_set) begin
      ptr_x_d = COORD_CTR;
      ptr_y_d = COORD_CTR;
    end else if (move_en) begin
      if (dp_io.move_right && !dp_io.move_left && (ptr_x_q != COORD_MAX)) begin
        ptr_x_d = ptr_x_q + 4'd1;
      end else if (dp_io.move_left && !dp_io.move_right && (ptr_x_q != '0)) begin
        ptr_x_d = ptr_x_q - 4'd1;
      end
      if (dp_io.move_down && !dp_io.move_up && (ptr_y_q != COORD_MAX)) begin
        ptr_y_d = ptr_y_q + 4'd1;
      end else if (dp_io.move_up && !dp_io.move_down && (ptr_y_q != '0)) begin
        ptr_y_d = ptr_y_q - 4'd1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_x_q  <= COORD_CTR;
      ptr_y_q  <= COORD_CTR;
      player_q <= 1'b0;
      legal_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      ptr_x_q  <= ptr_x_d;
      ptr_y_q  <= ptr_y_d;
      player_q <= player_d;
      legal_q  <= legal_d;
      count_q  <= count_d;
    end
  end

  // Outputs.
  always_comb begin
    dp_io.rd_cell     = rd_ok ? rd_raw : EMPTY;
    dp_io.pointer_x   = ptr_x_q;
    dp_io.pointer_y   = ptr_y_q;
    dp_io.player      = player_q;
    dp_io.legal       = legal_q;
    dp_io.stone_count = count_q;
    dp_io.board_full  = board_full;
  end

endmodule

// File: tb/tb_turn_datapath.sv
// Self-checking bench for turn_datapath: directed scenarios plus randomized play vs a board model.
module tb_turn_datapath;
  import gobang_pkg::*;

  logic clock = 1'b0;
  logic resetn;
  always #10 clock = ~clock;

  turn_datapath_if dp ();

  turn_datapath dut (
    .clock  (clock),
    .resetn (resetn),
    .dp_io  (dp)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: board contents and registers as plain integers.
  int mb [15][15];
  int mx, my, mpl, mlegal, mcount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp14(input int v);
    return (v < 0) ? 0 : ((v > 14) ? 14 : v);
  endfunction

  task automatic model_reset();
    for (int x = 0; x < 15; x++) for (int y = 0; y < 15; y++) mb[x][y] = 0;
    mx = 7; my = 7; mpl = 0; mlegal = 0; mcount = 0;
  endtask

  task automatic idle_inputs();
    dp.change_able_read = 0; dp.change_turn = 0; dp.control_set = 0; dp.put = 0;
    dp.move_up = 0; dp.move_down = 0; dp.move_left = 0; dp.move_right = 0;
  endtask

  // One clock with the given inputs; model applies the game rules on the same edge.
  task automatic cycle(input bit car, input bit ct, input bit cs, input bit pt,
                       input bit u, input bit d, input bit l, input bit r);
    int cx, cy;
    dp.change_able_read = car; dp.change_turn = ct; dp.control_set = cs; dp.put = pt;
    dp.move_up = u; dp.move_down = d; dp.move_left = l; dp.move_right = r;
    @(posedge clock);
    cx = mx; cy = my;
    if (ct) begin
      if (mlegal == 1 && mcount < 225) begin
        mb[cx][cy] = mpl + 1;
        mpl = 1 - mpl;
        mcount++;
      end
      mlegal = 0;
    end else if (car && pt) begin
      mlegal = (mb[cx][cy] == 0 && mcount != 225) ? 1 : 0;
    end
    if (cs) begin
      mx = 7; my = 7;
    end else if (car && !pt) begin
      mx = clamp14(mx + int'(r) - int'(l));
      my = clamp14(my + int'(d) - int'(u));
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic check_cell(input string tag, input int x, input int y);
    dp.rd_x = 4'(x); dp.rd_y = 4'(y);
    #1;
    check(tag, dp.rd_cell, (x < 15 && y < 15) ? mb[x][y] : 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".px"},    dp.pointer_x,   mx);
    check({tag, ".py"},    dp.pointer_y,   my);
    check({tag, ".player"}, dp.player,     mpl);
    check({tag, ".legal"}, dp.legal,       mlegal);
    check({tag, ".count"}, dp.stone_count, mcount);
    check({tag, ".full"},  dp.board_full,  (mcount == 225) ? 1 : 0);
  endtask

  task automatic goto(input string tag, input int tx, input int ty);
    int guard = 0;
    while ((mx != tx || my != ty) && guard < 40) begin
      cycle(1, 0, 0, 0, my > ty, my < ty, mx > tx, mx < tx);
      guard++;
    end
    check({tag, ".x"}, dp.pointer_x, tx);
    check({tag, ".y"}, dp.pointer_y, ty);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 0;
    model_reset();
    @(negedge clock);
    resetn = 1;
  endtask

  initial begin
    idle_inputs();
    dp.rd_x = 0; dp.rd_y = 0;
    resetn = 0;
    model_reset();
    #25;
    check_state("reset");
    check_cell("reset.cell00", 0, 0);
    check_cell("reset.cell77", 7, 7);
    check_cell("reset.cell1414", 14, 14);
    @(negedge clock);
    resetn = 1;
    @(negedge clock);

    // Saturating right steps.
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0, 0, 0, 1);
    check("sat.px", dp.pointer_x, 14);
    check("sat.py", dp.pointer_y, 7);

    // Moves ignored outside CHOICE; control_set still recentres.
    cycle(0, 0, 0, 0, 1, 0, 1, 0);
    check_state("ignored");
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    check_state("recentre");

    // First legal put at centre, then commit.
    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    check("put1.legal", dp.legal, 1);
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    check_cell("commit1.cell", 7, 7);
    check("commit1.cell_black", dp.rd_cell, 1);
    check("commit1.player", dp.player, 1);
    check("commit1.count", dp.stone_count, 1);
    check_state("commit1");

    // Occupied cell is illegal and the commit does nothing.
    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    check("put2.legal", dp.legal, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    check("commit2.cell", dp.rd_cell, 1);
    check("commit2.player", dp.player, 1);
    check("commit2.count", dp.stone_count, 1);

    // Opposing pulses cancel; control_set overrides a move.
    goto("to34", 3, 4);
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    check("cancel.px", dp.pointer_x, 3);
    check("cancel.py", dp.pointer_y, 4);
    cycle(1, 0, 1, 0, 1, 0, 0, 0);
    check("override.px", dp.pointer_x, 7);
    check("override.py", dp.pointer_y, 7);

    // Move with put: pointer must stay where legality was sampled.
    cycle(1, 0, 0, 1, 0, 0, 1, 0);
    check_state("moveput");

    check_cell("oob.x", 15, 3);
    check_cell("oob.y", 2, 15);

    // Randomized play against the model.
    for (int i = 0; i < 400; i++) begin
      int sel = $urandom_range(0, 9);
      if (sel < 2) begin
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
      end else if (sel == 2) begin
        cycle(0, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        cycle(1, 0, 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end
      check_state("rand");
      check_cell("rand.cell", $urandom_range(0, 15), $urandom_range(0, 15));
    end

    // Fill the whole board.
    do_reset();
    for (int y = 0; y < 15; y++) begin
      for (int x = 0; x < 15; x++) begin
        goto("fill.goto", x, y);
        cycle(1, 0, 0, 1, 0, 0, 0, 0);
        check("fill.legal", dp.legal, 1);
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        check("fill.count", dp.stone_count, mcount);
      end
    end
    check("full.flag", dp.board_full, 1);
    check("full.count", dp.stone_count, 225);
    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    check("full.legal", dp.legal, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    check_state("full.after");
    for (int y = 0; y < 15; y++) begin
      for (int x = 0; x < 15; x++) begin
        dp.rd_x = 4'(x); dp.rd_y = 4'(y);
        #1;
        check("full.scan", dp.rd_cell, (((y * 15 + x) % 2) == 0) ? 1 : 2);
      end
    end

    // Reset between legality latch and change_turn.
    do_reset();
    goto("rst.goto", 2, 3);
    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    check("rst.legal_before", dp.legal, 1);
    resetn = 0;
    model_reset();
    #2;
    check_state("rst.async");
    @(negedge clock);
    resetn = 1;
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    check_state("rst.after");
    check_cell("rst.cell23", 2, 3);
    check_cell("rst.cell77", 7, 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/turn_datapath.md
TURN_DATAPATH -- requirements
Module: turn_datapath

Interface
REQ-001 clock  input  1  system clock, 50 MHz; all state updates on rising edge.
REQ-002 resetn  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-003 change_able_read  input  1  from game FSM; high in CHOICE; enables pointer moves and legality sampling.
REQ-004 change_turn  input  1  from game FSM; single-cycle pulse in CHANGE; commits the stone and swaps player.
REQ-005 control_set  input  1  from game FSM; single-cycle pulse, coincident with change_turn; recentres the pointer.
REQ-006 put  input  1  player put key, level, already synchronised.
REQ-007 move_up, move_down, move_left, move_right  input  1 each  single-cycle pointer-step pulses.
REQ-008 rd_x, rd_y  input  4 each  display read coordinate.
REQ-009 rd_cell  output  2  board content at (rd_x, rd_y), combinational; 00 for coordinates above 14.
REQ-010 pointer_x, pointer_y  output  4 each  current pointer coordinate, range 0..14.
REQ-011 player  output  1  side to move: 0 = black, 1 = white.
REQ-012 legal  output  1  latched legality of the pending put.
REQ-013 stone_count  output  8  stones placed, range 0..225.
REQ-014 board_full  output  1  high when stone_count == 225.

Function
REQ-015 Board: 15x15 cells, 2 bits each; 00 empty, 01 black, 10 white.
REQ-016 Pointer moves only in cycles with change_able_read=1; each move pulse steps one cell.
REQ-017 Pointer steps saturate: no change at 0 (up/left) or 14 (down/right); no wrap-around.
REQ-018 Axes are independent; opposing pulses on one axis in the same cycle cancel (no move on that axis).
REQ-019 Legality: in a cycle with change_able_read=1 and put=1, legal <= (cell at the current pointer == empty) and board_full==0.
REQ-020 A move pulse and put in the same cycle: legality is evaluated at the pre-move pointer, and the move is suppressed.
REQ-021 On change_turn=1 with legal=1, the following three updates happen on the same edge:
- the cell at (pointer_x, pointer_y) <= player+1;
- player toggles;
- stone_count increments.
REQ-022 On change_turn=1 with legal=0, board, player and stone_count are unchanged.
REQ-023 legal clears to 0 on every change_turn cycle.
REQ-024 control_set=1 sets the pointer to (7,7) on the same edge as REQ-021. The write uses the pre-reset pointer value.
REQ-025 control_set overrides any coincident move pulse.
REQ-026 Commit latency: the updated cell is visible on rd_cell, and player is updated, one cycle after the change_turn edge.
REQ-027 Inputs asserted while change_able_read=0 and change_turn=0 are ignored, except control_set.
REQ-028 stone_count never exceeds 225; no write occurs once board_full=1.

Reset
REQ-029 resetn low immediately forces:
- all cells to 00;
- pointer to (7,7);
- player to 0;
- legal to 0;
- stone_count to 0.
REQ-030 Reset asserted mid-turn discards the pending legality; no partial write survives.

Structure
REQ-031 Package gobang_pkg holds:
- BOARD_SIZE=15, CENTER=7, MAX_STONES=225;
- cell encodings EMPTY/BLACK/WHITE;
- a 2-bit cell_t typedef.
REQ-032 Sub-module board_regs: a 225x2 register file with one synchronous write port and two combinational read ports (pointer, display), with async reset.
REQ-033 turn_datapath contains the pointer counters, legality latch, player flop and stone counter.

Verification
REQ-034 Reset, then 8 move_right pulses with change_able_read=1 -> pointer_x=14 (saturated), pointer_y=7.
REQ-035 From (7,7): put in CHOICE, then change_turn+control_set -> rd_cell(7,7)=01, player=1, stone_count=1, pointer (7,7).
REQ-036 Second put at (7,7) -> legal=0; after change_turn, cell stays 01, player stays 1, stone_count stays 1.
REQ-037 Pointer at (3,4), move_left and move_right in one cycle -> pointer (3,4); move_up with control_set -> pointer (7,7).
REQ-038 Fill 225 cells via legal puts -> board_full=1; a further put gives legal=0 and count stays 225.
REQ-039 Assert resetn low between the legality latch and change_turn -> board all 00, player 0, legal 0, no write after release.
